alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the sail-core DSP `alu` between two requesters, for example the integer pipeline and a coprocessor/test port. It accepts one operation at a time through a valid/ready handshake and registers the operands into the ALU. It captures the result and returns it, with the branch flag, to the granted requester through a held response handshake.

---
 rtl/alu_share_arb.sv | 110 +++++++++++
 tb/tb_alu_share_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational DSP ALU between two requesters.
// Define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module alu_share_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTL_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [CTL_W-1:0]  r0_ctl,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [DATA_W-1:0] r0_resp_data,
  output logic              r0_resp_branch,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [CTL_W-1:0]  r1_ctl,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W-1:0] r1_resp_data,
  output logic              r1_resp_branch,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_branch,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              gnt;
  logic              accept;
  logic              resp_hs;
  logic [DATA_W-1:0] res_data;
  logic              res_branch;

  // Grant is computed every cycle; it only matters when IDLE and rst_n is high.
  always_comb begin
    gnt = 1'b0;
    if (r0_valid && r1_valid) begin
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = ~last_grant;
`endif
    end else if (r1_valid) begin
      gnt = 1'b1;
    end
  end

  assign accept   = (state == IDLE) && rst_n && (r0_valid || r1_valid);
  assign r0_ready = accept && !gnt;
  assign r1_ready = accept && gnt;
  assign resp_hs  = grant_id ? r1_resp_ready : r0_resp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:                 state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      alu_ctl    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_data   <= '0;
      res_branch <= 1'b0;
    end else begin
      state <= state_nxt;
      // ALU operands only change on the accept edge so the DSP inputs stay quiet.
      if (accept) begin
        grant_id   <= gnt;
        last_grant <= gnt;
        alu_ctl    <= gnt ? r1_ctl : r0_ctl;
        alu_a      <= gnt ? r1_a   : r0_a;
        alu_b      <= gnt ? r1_b   : r0_b;
      end
      if (state == EXEC) begin
        res_data   <= alu_out;
        res_branch <= alu_branch;
      end
    end
  end

  assign busy           = (state != IDLE);
  assign r0_resp_valid  = (state == RESP) && !grant_id;
  assign r1_resp_valid  = (state == RESP) && grant_id;
  assign r0_resp_data   = res_data;
  assign r1_resp_data   = res_data;
  assign r0_resp_branch = res_branch;
  assign r1_resp_branch = res_branch;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a small behavioural ALU stub.
module tb_alu_share_arb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTL_W  = 7;

  localparam logic [CTL_W-1:0] OP_ADD = 7'h02;
  localparam logic [CTL_W-1:0] OP_SUB = 7'h06;
  localparam logic [CTL_W-1:0] OP_BEQ = 7'h10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r0_valid, r0_ready, r0_resp_valid, r0_resp_ready, r0_resp_branch;
  logic              r1_valid, r1_ready, r1_resp_valid, r1_resp_ready, r1_resp_branch;
  logic [CTL_W-1:0]  r0_ctl, r1_ctl, alu_ctl;
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b, r0_resp_data, r1_resp_data;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic              alu_branch, busy, grant_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: combinational from its registered inputs.
  always_comb begin
    alu_out    = '0;
    alu_branch = 1'b0;
    case (alu_ctl)
      OP_ADD: alu_out = alu_a + alu_b;
      OP_SUB: alu_out = alu_a - alu_b;
      OP_BEQ: begin
        alu_out    = alu_a - alu_b;
        alu_branch = (alu_a == alu_b);
      end
      default: ;
    endcase
  end

  alu_share_arb #(.DATA_W(DATA_W), .CTL_W(CTL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctl(r0_ctl), .r0_a(r0_a), .r0_b(r0_b),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_resp_data(r0_resp_data), .r0_resp_branch(r0_resp_branch),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctl(r1_ctl), .r1_a(r1_a), .r1_b(r1_b),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_resp_data(r1_resp_data), .r1_resp_branch(r1_resp_branch),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_branch(alu_branch),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " r0_resp_valid"}, 32'(r0_resp_valid), 0);
    check({tag, " r1_resp_valid"}, 32'(r1_resp_valid), 0);
  endtask

  // Runs one operation from the current negedge: accept, EXEC, RESP (+hold), handshake.
  task automatic do_op(input string tag, input int gnt, input logic [31:0] exp_data,
                       input logic exp_br, input int hold);
    logic [DATA_W-1:0] seen;
    #1;
    check({tag, " r0_ready"}, 32'(r0_ready), 32'(gnt == 0));
    check({tag, " r1_ready"}, 32'(r1_ready), 32'(gnt == 1));
    @(posedge clk); @(negedge clk);
    check({tag, " exec busy"}, 32'(busy), 1);
    check({tag, " exec grant_id"}, 32'(grant_id), 32'(gnt));
    check({tag, " exec no resp"}, 32'(r0_resp_valid | r1_resp_valid), 0);
    check({tag, " exec readies"}, 32'(r0_ready | r1_ready), 0);
    @(posedge clk); @(negedge clk);
    check({tag, " resp_valid owner"}, 32'(gnt ? r1_resp_valid : r0_resp_valid), 1);
    check({tag, " resp_valid other"}, 32'(gnt ? r0_resp_valid : r1_resp_valid), 0);
    seen = gnt ? r1_resp_data : r0_resp_data;
    check({tag, " resp_data"}, seen, exp_data);
    check({tag, " resp_branch"}, 32'(gnt ? r1_resp_branch : r0_resp_branch), 32'(exp_br));
    // Non-owner readiness must be ignored while the owner back-pressures.
    if (gnt == 0) r1_resp_ready = 1'b1; else r0_resp_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check({tag, " hold valid"}, 32'(gnt ? r1_resp_valid : r0_resp_valid), 1);
      check({tag, " hold data"}, gnt ? r1_resp_data : r0_resp_data, exp_data);
      check({tag, " hold readies"}, 32'(r0_ready | r1_ready), 0);
    end
    r0_resp_ready = (gnt == 0);
    r1_resp_ready = (gnt == 1);
    @(posedge clk); @(negedge clk);
    r0_resp_ready = 1'b0;
    r1_resp_ready = 1'b0;
    check_idle_outputs({tag, " after hs"});
  endtask

  initial begin
    int exp_gnt [6];
    rst_n = 1'b0;
    r0_valid = 1'b1; r0_ctl = OP_ADD; r0_a = 32'd1; r0_b = 32'd2; r0_resp_ready = 1'b0;
    r1_valid = 1'b1; r1_ctl = OP_ADD; r1_a = 32'd3; r1_b = 32'd4; r1_resp_ready = 1'b0;

    // Reset state, with requests present that must not be acknowledged.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset grant_id", 32'(grant_id), 0);
    check("reset r0_ready", 32'(r0_ready), 0);
    check("reset r1_ready", 32'(r1_ready), 0);
    check("reset alu_ctl", 32'(alu_ctl), 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_b", alu_b, 0);
    check("reset resp_data", r0_resp_data, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD on port 0.
    r0_valid = 1'b1; r0_ctl = OP_ADD; r0_a = 32'd10000; r0_b = 32'd111;
    do_op("add0", 0, 32'd10111, 1'b0, 0);
    r0_valid = 1'b0;
    @(negedge clk);

    // Port 1 op aborted by a reset pulse during EXEC.
    r1_valid = 1'b1; r1_ctl = OP_SUB; r1_a = 32'd50; r1_b = 32'd8;
    #1;
    check("abort r1_ready", 32'(r1_ready), 1);
    @(posedge clk); @(negedge clk);
    r1_valid = 1'b0;
    check("abort in exec", 32'(busy), 1);
    check("abort alu_a", alu_a, 32'd50);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort rst");
    check("abort grant_id", 32'(grant_id), 0);
    check("abort alu_a", alu_a, 0);
    check("abort alu_ctl", 32'(alu_ctl), 0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check_idle_outputs("abort quiet");
    end

    // Continuous contention; port 0 must win first after the reset.
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0, 0, 0};
`else
    exp_gnt = '{0, 1, 0, 1, 0, 1};
`endif
    r0_valid = 1'b1; r0_ctl = OP_ADD; r0_a = 32'd5;  r0_b = 32'd3;
    r1_valid = 1'b1; r1_ctl = OP_SUB; r1_a = 32'd20; r1_b = 32'd7;
    for (int k = 0; k < 6; k++) begin
      do_op($sformatf("cont%0d", k), exp_gnt[k],
            (exp_gnt[k] == 0) ? 32'd8 : 32'd13, 1'b0, (k == 3) ? 5 : 0);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);

    // Back-pressure on port 1 alone, then the next accept in the following cycle.
    r1_valid = 1'b1; r1_ctl = OP_SUB; r1_a = 32'd1000; r1_b = 32'd1;
    do_op("bp1", 1, 32'd999, 1'b0, 5);
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_ctl = OP_ADD; r0_a = 32'hFFFF_FFFF; r0_b = 32'd2;
    do_op("bp_next", 0, 32'd1, 1'b0, 0);
    r0_valid = 1'b0;
    @(negedge clk);

    // Branch flag with equal compare operands.
    r1_valid = 1'b1; r1_ctl = OP_BEQ; r1_a = 32'd42; r1_b = 32'd42;
    do_op("beq", 1, 32'd0, 1'b1, 1);
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_ctl = OP_BEQ; r0_a = 32'd42; r0_b = 32'd41;
    do_op("bne", 0, 32'd1, 1'b0, 0);
    r0_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
